rx_frame_ctrl: RTL

- Drains the 8-entry UART receive FIFO through its ready/read handshake and parses the byte stream into frames.
- Frame format: SYNC(0xA5), LEN, LEN payload bytes, CHK.
- Forwards payload bytes downstream with valid/ready backpressure and reports a per-frame ok/error result.
- Sits between the UART receiver and the command decoder.

---
 rtl/rx_frame_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_ctrl.sv
// Receive-FIFO frame parser: SYNC, LEN, payload, XOR checksum; payload forwarded with valid/ready.
// Optional RX_FRAME_STATS_EN adds saturating good/bad frame counters.
module rx_frame_ctrl #(
    parameter int unsigned MAX_LEN   = 16,
    parameter int unsigned TIMEOUT   = 50000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ready,
    input  logic [7:0]  i_D,
    output logic        o_read,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_last,
    input  logic        i_out_ready,
    output logic        o_frame_ok,
    output logic        o_frame_err,
`ifdef RX_FRAME_STATS_EN
    output logic [15:0] o_good_cnt,
    output logic [15:0] o_bad_cnt,
`endif
    output logic [1:0]  o_err_code
);

    typedef enum logic [1:0] {
        HUNT,
        LEN,
        DATA,
        CHK
    } state_t;

    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  chk_q, chk_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic        stalled;

    assign o_read  = i_ready && !i_rst && (state_q != DATA || !valid_q || i_out_ready);
    assign stalled = (state_q == DATA) && valid_q && !i_out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;

        if (valid_q && i_out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            HUNT: begin
                if (o_read && i_D == SYNC_BYTE) state_d = LEN;
            end
            LEN: begin
                if (o_read) begin
                    chk_d = i_D;
                    cnt_d = i_D;
                    if (i_D > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                        state_d = HUNT;
                    end else if (i_D == 8'd0) begin
                        state_d = CHK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (o_read) begin
                    data_d  = i_D;
                    valid_d = 1'b1;
                    last_d  = (cnt_q == 8'd1);
                    chk_d   = chk_q ^ i_D;
                    cnt_d   = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = CHK;
                end
            end
            CHK: begin
                if (o_read) begin
                    if (i_D == chk_q) begin
                        ok_d   = 1'b1;
                        code_d = 2'd0;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'd1;
                    end
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase

        // A pop in the expiry cycle wins; downstream stall freezes the idle count.
        if (state_q != HUNT) begin
            if (o_read) begin
                tmo_d = '0;
            end else if (!stalled) begin
                if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                    state_d = HUNT;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
        end
        if (state_d == HUNT) tmo_d = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            chk_q   <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_last      = last_q;
    assign o_frame_ok  = ok_q;
    assign o_frame_err = err_q;
    assign o_err_code  = code_q;

`ifdef RX_FRAME_STATS_EN
    logic [15:0] good_q, good_d;
    logic [15:0] bad_q, bad_d;

    always_comb begin
        good_d = good_q;
        bad_d  = bad_q;
        if (ok_q && good_q != '1) good_d = good_q + 16'd1;
        if (err_q && bad_q != '1) bad_d = bad_q + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            good_q <= good_d;
            bad_q  <= bad_d;
        end
    end

    assign o_good_cnt = good_q;
    assign o_bad_cnt  = bad_q;
`endif

endmodule
